// File: rtl/ptw_pkg.sv
// Shared PTW definitions: FSM state encoding, PTE bit positions
// and the default physical address width for the Sv32 walkers.
package ptw_pkg;

  localparam int PTW_ADDR_W = 32;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t ISSUE = 1'b1;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

endpackage

// File: rtl/ptw_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo N. Ports: req, ptr in; one-hot gnt and its index idx out.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW:0]   s;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N))
        s = s - (IW+1)'(N);
      j = s[IW-1:0];
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptw_arbiter.sv
// Round-robin share of one PTW memory read port among N_REQ MMU walkers.
// Ports: req_valid/req_addr in, req_ack/req_rdata out (walker side);
// mem_req/mem_addr out, mem_rdata/mem_ack in (memory side);
// busy, grant_id, timeout_err status. Optional watchdog: PTW_TIMEOUT_EN.
module ptw_arbiter
  import ptw_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = PTW_ADDR_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ack,
  output logic [31:0]             req_rdata,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                    timeout_err
);

  localparam int IW = $clog2(N_REQ);

  state_t           state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    nxt_ptr;
  logic [N_REQ-1:0] owner_oh;
  logic             owner_live;
  logic [ADDR_W-1:0] addr_q;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  logic in_issue;
  logic owner_req;
  logic to_fire;
  logic done;

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign in_issue  = (state == ISSUE);
  assign owner_req = |(req_valid & owner_oh);
  assign done      = in_issue && (mem_ack || to_fire);
  assign nxt_ptr   = (owner == IW'(N_REQ-1)) ? '0
                   : owner + IW'(1);

`ifdef PTW_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tcnt;

  // Held at zero outside ISSUE, so the first ISSUE cycle counts as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt <= '0;
    else if (!in_issue)
      tcnt <= '0;
    else if (!mem_ack)
      tcnt <= tcnt + TW'(1);
  end

  assign to_fire = in_issue && !mem_ack
                && (tcnt == TW'(TIMEOUT_CYCLES-1));
  assign timeout_err = to_fire;
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A dropped owner still completes the bus read; only the return is
  // suppressed. Gating with req_valid covers the drop cycle itself.
  assign req_ack = (done && owner_live)
                 ? (req_valid & owner_oh) : '0;
  assign req_rdata = (done && owner_live && mem_ack)
                   ? mem_rdata : 32'h0;

  assign mem_req  = in_issue;
  assign busy     = in_issue;
  assign mem_addr = addr_q;
  assign grant_id = owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      owner_oh   <= '0;
      owner_live <= 1'b0;
      rr_ptr     <= '0;
      addr_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            owner      <= pick_idx;
            owner_oh   <= pick_gnt;
            addr_q     <= addr_arr[pick_idx];
            owner_live <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!owner_req)
            owner_live <= 1'b0;
          if (done) begin
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
`ifndef PTW_TIMEOUT_EN
  a_no_idle_ack: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(mem_ack && !in_issue));
`endif
`endif

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: reset, single walker, contention,
// owner drop, reset mid-ISSUE, watchdog and a fairness soak.
module tb_ptw_arbiter;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int TO     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [1:0]  req_ack;
  logic [31:0] req_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic [0:0]  grant_id;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ptw_arbiter #(
    .N_REQ          (N_REQ),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ack     (req_ack),
    .req_rdata   (req_rdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_req got %b want 0", mem_req);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mem_addr got %h want 0", mem_addr);
    end
    checks++;
    if (req_ack !== 2'b00) begin
      errors++;
      $display("FAIL rst_req_ack got %b want 00", req_ack);
    end
    checks++;
    if (req_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata got %h want 0", req_rdata);
    end
    checks++;
    if (busy !== 1'b0 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_gid got %b/%b want 0/0",
               busy, grant_id);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_tmo got %b want 0", timeout_err);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_addr[31:0] = 32'h8000_1004;
    req_valid      = 2'b01;
    wait_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_req got timeout want mem_req");
    end
    checks++;
    if (mem_addr !== 32'h8000_1004 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_addr got %h/%b want 80001004/1",
               mem_addr, busy);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (req_ack !== 2'b00 || mem_req !== 1'b1) begin
        errors++;
        $display("FAIL single_wait got %b/%b want 00/1",
                 req_ack, mem_req);
      end
    end
    cyc();
    mem_rdata = 32'h2000_0C01;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b01 || req_rdata !== 32'h2000_0C01) begin
      errors++;
      $display("FAIL single_ack got %b/%h want 01/20000c01",
               req_ack, req_rdata);
    end
    cyc();
    mem_ack   = 1'b0;
    req_valid = 2'b00;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || req_ack !== 2'b00) begin
      errors++;
      $display("FAIL single_idle got %b/%b/%b want 0/0/00",
               mem_req, busy, req_ack);
    end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    req_addr  = {32'h8000_2008, 32'h8000_1004};
    req_valid = 2'b11;
    wait_req(ok);
    checks++;
    if (!ok || grant_id !== 1'b0 || mem_addr !== 32'h8000_1004) begin
      errors++;
      $display("FAIL cont_g1 got %b/%0d/%h want 1/0/80001004",
               ok, grant_id, mem_addr);
    end
    mem_rdata = 32'h1111_0001;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b01 || req_rdata !== 32'h1111_0001) begin
      errors++;
      $display("FAIL cont_a1 got %b/%h want 01/11110001",
               req_ack, req_rdata);
    end
    req_addr[31:0] = 32'h9000_0ff0;
    cyc();
    mem_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || grant_id !== 1'b1 || mem_addr !== 32'h8000_2008) begin
      errors++;
      $display("FAIL cont_g2 got %b/%0d/%h want 1/1/80002008",
               ok, grant_id, mem_addr);
    end
    mem_rdata = 32'h2222_0001;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b10 || req_rdata !== 32'h2222_0001) begin
      errors++;
      $display("FAIL cont_a2 got %b/%h want 10/22220001",
               req_ack, req_rdata);
    end
    req_valid[1] = 1'b0;
    cyc();
    mem_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || grant_id !== 1'b0 || mem_addr !== 32'h9000_0ff0) begin
      errors++;
      $display("FAIL cont_g3 got %b/%0d/%h want 1/0/90000ff0",
               ok, grant_id, mem_addr);
    end
    mem_rdata = 32'h3333_0001;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b01 || req_rdata !== 32'h3333_0001) begin
      errors++;
      $display("FAIL cont_a3 got %b/%h want 01/33330001",
               req_ack, req_rdata);
    end
    req_valid = 2'b00;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic test_owner_drop();
    bit ok;
    do_reset();
    req_addr  = {32'h8000_3000, 32'h8000_1000};
    req_valid = 2'b01;
    wait_req(ok);
    mem_rdata = 32'h0000_00c1;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (!ok || req_ack !== 2'b01) begin
      errors++;
      $display("FAIL drop_setup got %b/%b want 1/01", ok, req_ack);
    end
    req_valid = 2'b10;
    cyc();
    mem_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL drop_grant got %b/%0d want 1/1", ok, grant_id);
    end
    cyc();
    req_valid = 2'b00;
    cyc();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_3000) begin
      errors++;
      $display("FAIL drop_hold got %b/%h want 1/80003000",
               mem_req, mem_addr);
    end
    cyc();
    req_valid = 2'b11;
    mem_rdata = 32'hdead_beef;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b00) begin
      errors++;
      $display("FAIL drop_noack got %b want 00", req_ack);
    end
    cyc();
    mem_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || grant_id !== 1'b0 || mem_addr !== 32'h8000_1000) begin
      errors++;
      $display("FAIL drop_next got %b/%0d/%h want 1/0/80001000",
               ok, grant_id, mem_addr);
    end
    mem_rdata = 32'h0000_00c3;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b01 || req_rdata !== 32'h0000_00c3) begin
      errors++;
      $display("FAIL drop_ack got %b/%h want 01/000000c3",
               req_ack, req_rdata);
    end
    req_valid = 2'b00;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    req_addr  = {32'h8000_5000, 32'h8000_4000};
    req_valid = 2'b01;
    wait_req(ok);
    mem_ack = 1'b1;
    #1;
    req_valid = 2'b10;
    cyc();
    mem_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL rmid_grant got %b/%0d want 1/1", ok, grant_id);
    end
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async got %b/%b/%0d want 0/0/0",
               mem_req, busy, grant_id);
    end
    cyc();
    rst_n = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok || grant_id !== 1'b0 || mem_addr !== 32'h8000_4000) begin
      errors++;
      $display("FAIL rmid_fresh got %b/%0d/%h want 1/0/80004000",
               ok, grant_id, mem_addr);
    end
    mem_rdata = 32'h0000_0401;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b01) begin
      errors++;
      $display("FAIL rmid_ack got %b want 01", req_ack);
    end
    req_valid = 2'b00;
    cyc();
    mem_ack = 1'b0;
  endtask

`ifdef PTW_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit early;
    do_reset();
    req_addr[31:0] = 32'h8000_6000;
    mem_rdata      = 32'hffff_ffff;
    req_valid      = 2'b01;
    wait_req(ok);
    early = 1'b0;
    for (int i = 1; i < TO; i++) begin
      if (timeout_err || req_ack != 2'b00 || !mem_req)
        early = 1'b1;
      cyc();
    end
    checks++;
    if (!ok || early) begin
      errors++;
      $display("FAIL tmo_early got ok=%b early=%b want 1/0",
               ok, early);
    end
    checks++;
    if (req_ack !== 2'b01 || req_rdata !== 32'h0
        || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire got %b/%h/%b want 01/0/1",
               req_ack, req_rdata, timeout_err);
    end
    req_valid = 2'b00;
    cyc();
    checks++;
    if (mem_req !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after got %b/%b want 0/0",
               mem_req, timeout_err);
    end
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    bit bad;
    do_reset();
    req_addr[31:0] = 32'h8000_6000;
    req_valid      = 2'b01;
    wait_req(ok);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_err || !mem_req || req_ack != 2'b00)
        bad = 1'b1;
      cyc();
    end
    checks++;
    if (!ok || bad) begin
      errors++;
      $display("FAIL notmo_wait got ok=%b bad=%b want 1/0", ok, bad);
    end
    mem_rdata = 32'h0000_0601;
    mem_ack   = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b01 || req_rdata !== 32'h0000_0601) begin
      errors++;
      $display("FAIL notmo_ack got %b/%h want 01/00000601",
               req_ack, req_rdata);
    end
    req_valid = 2'b00;
    cyc();
    mem_ack = 1'b0;
  endtask
`endif

  task automatic test_fairness_soak();
    bit          ok;
    int          own;
    int          lat;
    int          cnt [2];
    logic [31:0] addr [2];
    logic [31:0] exp_d;
    logic [1:0]  exp_ack;
    do_reset();
    addr[0]   = 32'h8010_0000;
    addr[1]   = 32'h8020_0000;
    cnt[0]    = 0;
    cnt[1]    = 0;
    own       = 0;
    req_addr  = {addr[1], addr[0]};
    req_valid = 2'b11;
    for (int t = 0; t < 1000; t++) begin
      wait_req(ok);
      checks++;
      if (!ok || grant_id !== own[0] || mem_addr !== addr[own]) begin
        errors++;
        if (errors < 20)
          $display("FAIL soak_grant t=%0d got %b/%0d/%h want 1/%0d/%h",
                   t, ok, grant_id, mem_addr, own, addr[own]);
        if (!ok)
          break;
      end
      lat = $urandom_range(1, 5);
      for (int i = 1; i < lat; i++)
        cyc();
      exp_d     = addr[own] ^ 32'ha5a5_5a5a;
      exp_ack   = 2'b01 << own;
      mem_rdata = exp_d;
      mem_ack   = 1'b1;
      #1;
      checks++;
      if (req_ack !== exp_ack || req_rdata !== exp_d) begin
        errors++;
        if (errors < 20)
          $display("FAIL soak_ack t=%0d got %b/%h want %b/%h",
                   t, req_ack, req_rdata, exp_ack, exp_d);
      end
      cnt[own]++;
      addr[own] = addr[own] + 32'd4;
      req_addr  = {addr[1], addr[0]};
      own       = 1 - own;
      cyc();
      mem_ack = 1'b0;
    end
    checks++;
    if (cnt[0] - cnt[1] > 1 || cnt[1] - cnt[0] > 1
        || cnt[0] + cnt[1] != 1000) begin
      errors++;
      $display("FAIL soak_fair got %0d/%0d want 500/500",
               cnt[0], cnt[1]);
    end
    req_valid = 2'b00;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_owner_drop();
    test_reset_mid();
`ifdef PTW_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_fairness_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
